fir_mc_filter: RTL and testbench

- Parametrised, multi-channel, time-multiplexed FIR filter; next generation of the team's fixed single-channel 16-bit lowpass FIR.
- One shared multiplier serves all channels. Each channel has its own circular delay line. Coefficients are runtime-loadable.
- Valid/ready input with channel tag; pulsed output with channel tag.
- Sits between sample source (ADC/test-vector feeder) and downstream decimator/logger.

---
 rtl/fir_mc_pkg.sv | 53 +++++
 rtl/fir_mc_delay_mem.sv | 76 +++++++
 rtl/fir_mc_filter.sv | 176 +++++++++++++++++
 tb/tb_fir_mc_filter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mc_pkg
//  Purpose  : Shared types and arithmetic helpers for the multi-channel FIR.
//             The FIR_MC_ROUND_SAT_EN macro selects round-half-up with
//             saturation. Without it, the output path truncates (floor) and
//             wraps.
//  Revision : 1.0 - initial release
// ============================================================================
package fir_mc_pkg;

  // Width of the signed scratch value that round_sat operates on.
  localparam int RS_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  // Accumulator width. It holds TAPS full-precision products without overflow.
  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Convert the Q(COEF_W-1) accumulator into an output sample.
  // The caller keeps the low data_w bits of the returned value.
  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     coef_w,
    input int                     data_w
  );
    logic signed [RS_W-1:0] res;
`ifdef FIR_MC_ROUND_SAT_EN
    logic signed [RS_W-1:0] max_v;
    logic signed [RS_W-1:0] min_v;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    res   = (acc + (64'sd1 <<< (coef_w - 2))) >>> (coef_w - 1);
    if (res > max_v) begin
      res = max_v;
    end else if (res < min_v) begin
      res = min_v;
    end
`else
    // Floor and keep only the low data_w bits, so overflow wraps around.
    res = (acc >>> (coef_w - 1)) & ((64'sd1 <<< data_w) - 64'sd1);
`endif
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mc_delay_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mc_delay_mem
//  Purpose  : Per-channel circular sample history for the multi-channel FIR.
//             Each channel has a write port at its head and a head pointer.
//             The read port returns x[n-k] for (chan, k). The read index is
//             (head - k) mod TAPS.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_mc_delay_mem #(
  parameter int DATA_W   = 16,
  parameter int TAPS     = 8,
  parameter int CHANNELS = 2,
  parameter int CHAN_W   = 1,
  parameter int TAP_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [CHAN_W-1:0] wr_chan_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              adv_en_i,
  input  logic [CHAN_W-1:0] adv_chan_i,
  input  logic [CHAN_W-1:0] rd_chan_i,
  input  logic [TAP_W-1:0]  rd_k_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam logic [TAP_W:0]   TAPS_X    = (TAP_W + 1)'(TAPS);
  localparam logic [TAP_W-1:0] HEAD_LAST = TAP_W'(TAPS - 1);

  logic [CHANNELS*DATA_W-1:0] rd_flat;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [DATA_W-1:0] mem_q [TAPS];
    logic [TAP_W-1:0]  head_q;
    logic [TAP_W:0]    rd_sum;
    logic [TAP_W-1:0]  rd_idx;

    // head + TAPS - k always fits TAP_W+1 bits, and one conditional subtract
    // brings it back into range.
    assign rd_sum = {1'b0, head_q} + TAPS_X - {1'b0, rd_k_i};
    assign rd_idx = (rd_sum >= TAPS_X) ? TAP_W'(rd_sum - TAPS_X) : rd_sum[TAP_W-1:0];
    assign rd_flat[c*DATA_W +: DATA_W] = mem_q[rd_idx];

    // Store the sample at this channel's head. Advance the head once its
    // result has been delivered.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        head_q <= '0;
        for (int t = 0; t < TAPS; t++) begin
          mem_q[t] <= '0;
        end
      end else begin
        if (wr_en_i && (wr_chan_i == CHAN_W'(c))) begin
          mem_q[head_q] <= wr_data_i;
        end
        if (adv_en_i && (adv_chan_i == CHAN_W'(c))) begin
          head_q <= (head_q == HEAD_LAST) ? '0 : head_q + 1'b1;
        end
      end
    end
  end

  // Select the read data of the requested channel.
  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_chan_i == CHAN_W'(c)) begin
        rd_data_o = rd_flat[c*DATA_W +: DATA_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_mc_filter.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mc_filter
//  Purpose  : Time-multiplexed multi-channel FIR with one shared multiplier.
//             The coefficient set is shared by all channels and can be
//             loaded at runtime. Input uses valid/ready with a channel tag.
//             Each result is a single-cycle pulse tagged with its channel.
//             FIR_MC_ROUND_SAT_EN enables round-half-up with saturation.
//             Without it, the output is truncated and wraps on overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_mc_filter
  import fir_mc_pkg::*;
#(
  parameter int  DATA_W   = 16,
  parameter int  COEF_W   = 16,
  parameter int  TAPS     = 8,
  parameter int  CHANNELS = 2,
  localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TAP_W    = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic [DATA_W-1:0] in_data,
  input  logic              coef_we,
  input  logic [TAP_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [CHAN_W-1:0] out_chan,
  output logic [DATA_W-1:0] out_data
);

  localparam int             ACC_W   = acc_w(DATA_W, COEF_W, TAPS);
  localparam int             PROD_W  = DATA_W + COEF_W;
  localparam logic [TAP_W:0] CNT_END = (TAP_W + 1)'(TAPS);

  fir_state_e        state_q;
  logic              in_ready_q;
  logic [CHAN_W-1:0] chan_q;
  logic [TAP_W:0]    cnt_q;
  logic [PROD_W-1:0] prod_q;
  logic              prod_vld_q;
  logic [ACC_W-1:0]  acc_q;
  logic [COEF_W-1:0] coef_q [TAPS];
  logic              out_valid_q;
  logic [CHAN_W-1:0] out_chan_q;
  logic [DATA_W-1:0] out_data_q;

  logic              chan_ok;
  logic              accept;
  logic              coef_ok;
  logic [TAP_W-1:0]  k_idx;
  logic [DATA_W-1:0] rd_data;
  logic [COEF_W-1:0] coef_cur;
  logic [PROD_W-1:0] prod_d;
  logic [ACC_W-1:0]  prod_ext;
  logic [DATA_W-1:0] out_data_d;

  assign chan_ok = ({1'b0, in_chan} < (CHAN_W + 1)'(CHANNELS));
  assign accept  = (state_q == ST_IDLE) && in_ready_q && in_valid && chan_ok;
  assign coef_ok = (state_q == ST_IDLE) && coef_we &&
                   ({1'b0, coef_addr} < (TAP_W + 1)'(TAPS));

  // The tap index is held at 0 once all products are issued. This keeps
  // the coefficient and history reads in range.
  assign k_idx    = (cnt_q < CNT_END) ? cnt_q[TAP_W-1:0] : '0;
  assign coef_cur = coef_q[k_idx];

  // Both operands are sign-extended to the full product width, so the
  // low PROD_W bits of the product are exact.
  assign prod_d = $signed({{DATA_W{coef_cur[COEF_W-1]}}, coef_cur}) *
                  $signed({{COEF_W{rd_data[DATA_W-1]}}, rd_data});
  assign prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};

  assign out_data_d = DATA_W'(round_sat(RS_W'($signed(acc_q)), COEF_W, DATA_W));

  fir_mc_delay_mem #(
    .DATA_W   (DATA_W),
    .TAPS     (TAPS),
    .CHANNELS (CHANNELS),
    .CHAN_W   (CHAN_W),
    .TAP_W    (TAP_W)
  ) u_delay_mem (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (accept),
    .wr_chan_i  (in_chan),
    .wr_data_i  (in_data),
    .adv_en_i   (state_q == ST_OUT),
    .adv_chan_i (chan_q),
    .rd_chan_i  (chan_q),
    .rd_k_i     (k_idx),
    .rd_data_o  (rd_data)
  );

  // Coefficient bank. Writes are taken only in IDLE. A write in the same
  // cycle as an accepted sample is already in place for its first product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < TAPS; t++) begin
        coef_q[t] <= '0;
      end
    end else if (coef_ok) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // Control FSM: accept a sample, run TAPS pipelined MACs, then emit a
  // one-cycle result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      chan_q      <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            chan_q     <= in_chan;
            acc_q      <= '0;
            cnt_q      <= '0;
            prod_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= ST_MAC;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_MAC: begin
          if (cnt_q < CNT_END) begin
            prod_q     <= prod_d;
            prod_vld_q <= 1'b1;
            cnt_q      <= cnt_q + 1'b1;
          end else begin
            prod_vld_q <= 1'b0;
          end
          if (prod_vld_q) begin
            acc_q <= acc_q + prod_ext;
          end
          // The last product is added on the same edge as this transition.
          if ((cnt_q == CNT_END) && prod_vld_q) begin
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
          out_valid_q <= 1'b1;
          out_data_q  <= out_data_d;
          out_chan_q  <= chan_q;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mc_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_mc_filter
//  Purpose  : Directed self-checking bench for fir_mc_filter. Expected
//             values depend on whether FIR_MC_ROUND_SAT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mc_filter;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int TAPS     = 8;
  localparam int CHANNELS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_chan;
  logic [15:0] in_data;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        out_valid;
  logic [0:0]  out_chan;
  logic [15:0] out_data;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] exp_imp [8];
  logic [15:0] exp_ov1, exp_ov3, exp_ov8, exp_same;

  fir_mc_filter #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .TAPS     (TAPS),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chan   (in_chan),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [15:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(posedge clk); #1;
    coef_we   = 1'b0;
  endtask

  // coef_mode: 0 = none, 1 = write coef[0]=0x1000 with the sample,
  //            2 = write coef[0]=0x7FFF while the filter is busy.
  task automatic run_sample(input logic ch, input logic [15:0] d, input int coef_mode,
                            output logic [15:0] res, output logic rch,
                            output int lat, output bit rdy_err);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_chan  = ch;
    in_data  = d;
    if (coef_mode == 1) begin
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h1000;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    if (coef_mode == 2) begin
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h7FFF;
    end
    lat = 0;
    rdy_err = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_err = 1'b1;
      if (lat == 5) coef_we = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    coef_we = 1'b0;
    if (!out_valid) check("out_timeout", {31'd0, out_valid}, 32'd1);
    res = out_data;
    rch = out_chan;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    logic        rch;
    int          lat;
    bit          rerr;
    int          pulses;

`ifdef FIR_MC_ROUND_SAT_EN
    exp_imp  = '{16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h2800, 16'h3000, 16'h3800, 16'h4000};
    exp_ov1  = 16'h4000;
    exp_ov3  = 16'h7FFF;
    exp_ov8  = 16'h7FFF;
    exp_same = 16'h2000;
`else
    exp_imp  = '{16'h07FF, 16'h0FFF, 16'h17FF, 16'h1FFF, 16'h27FF, 16'h2FFF, 16'h37FF, 16'h3FFF};
    exp_ov1  = 16'h3FFF;
    exp_ov3  = 16'hBFFE;
    exp_ov8  = 16'hFFFC;
    exp_same = 16'h1FFF;
`endif

    in_valid = 1'b0; in_chan = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    reset = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_out_chan",  {31'd0, out_chan},  32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Impulse on ch0
    for (int k = 0; k < 8; k++) write_coef(3'(k), 16'(16'h0800 * (k + 1)));
    for (int i = 0; i < 8; i++) begin
      run_sample(1'b0, (i == 0) ? 16'h7FFF : 16'h0000, 0, res, rch, lat, rerr);
      check($sformatf("imp_data_%0d", i), {16'd0, res}, {16'd0, exp_imp[i]});
      if (i == 0) begin
        check("imp_chan",        {31'd0, rch},      32'd0);
        check("latency",         lat,               32'd10);
        check("ready_low_busy",  {31'd0, rerr},     32'd0);
        check("ready_at_output", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("pulse_width",     {31'd0, out_valid}, 32'd0);
        check("out_hold",        {16'd0, out_data},  {16'd0, exp_imp[0]});
      end
    end

    // Channel isolation: ch1 impulse interleaved with zeros on ch0
    for (int i = 0; i < 8; i++) begin
      run_sample(1'b1, (i == 0) ? 16'h7FFF : 16'h0000, 0, res, rch, lat, rerr);
      check($sformatf("iso_ch1_data_%0d", i), {16'd0, res}, {16'd0, exp_imp[i]});
      check($sformatf("iso_ch1_chan_%0d", i), {31'd0, rch}, 32'd1);
      run_sample(1'b0, 16'h0000, 0, res, rch, lat, rerr);
      check($sformatf("iso_ch0_data_%0d", i), {16'd0, res}, 32'd0);
      check($sformatf("iso_ch0_chan_%0d", i), {31'd0, rch}, 32'd0);
    end

    // A coefficient write while busy is ignored, so the old coef[0] applies.
    run_sample(1'b1, 16'h7FFF, 2, res, rch, lat, rerr);
    check("busy_coef_ignored", {16'd0, res}, {16'd0, exp_imp[0]});
    // A write together with an accepted sample is used by that sample.
    run_sample(1'b1, 16'h7FFF, 1, res, rch, lat, rerr);
    check("same_cycle_coef", {16'd0, res}, {16'd0, exp_same});

    // Overflow: all coefficients 0.5, full-scale input on ch0
    for (int k = 0; k < 8; k++) write_coef(3'(k), 16'h4000);
    for (int i = 0; i < 8; i++) begin
      run_sample(1'b0, 16'h7FFF, 0, res, rch, lat, rerr);
      if (i == 0) check("ovf_out1", {16'd0, res}, {16'd0, exp_ov1});
      if (i == 1) check("ovf_out2", {16'd0, res}, 32'h7FFF);
      if (i == 2) check("ovf_out3", {16'd0, res}, {16'd0, exp_ov3});
      if (i == 7) check("ovf_out8", {16'd0, res}, {16'd0, exp_ov8});
    end

    // Reset three cycles into MAC
    in_valid = 1'b1; in_chan = 1'b0; in_data = 16'h1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data",  {16'd0, out_data},  32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("midrst_no_pulse", pulses, 32'd0);
    for (int i = 0; i < 3; i++) begin
      run_sample(1'b0, (i == 0) ? 16'h7FFF : 16'h0000, 0, res, rch, lat, rerr);
      check($sformatf("post_rst_data_%0d", i), {16'd0, res}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
